// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the SRP16 memory-port arbiter: owner encodings and default widths.
package mem_bus_arbiter_pkg;

  localparam int unsigned DefAddrW = 16;
  localparam int unsigned DefDataW = 16;

  typedef enum logic [1:0] {
    OwnNone = 2'd0,
    OwnM0   = 2'd1,
    OwnM1   = 2'd2
  } owner_e;

endpackage

// File: rtl/bus_arb_pick.sv
// Combinational next-owner selection for the two-requester memory bus arbiter.
module bus_arb_pick
  import mem_bus_arbiter_pkg::*;
(
  input  logic       m0_req_i,
  input  logic       m1_req_i,
  input  logic       m0_lock_i,
  input  logic       m1_lock_i,
  input  logic [1:0] owner_i,
  input  logic [1:0] last_i,
  input  logic       xfer_i,
  input  logic       hold_max_i,
  output logic [1:0] owner_o
);

  logic       own_req;
  logic       oth_req;
  logic       own_lock;
  logic [1:0] oth;

  // Map the current owner's view onto "own" / "other" signals.
  always_comb begin
    own_req  = 1'b0;
    oth_req  = 1'b0;
    own_lock = 1'b0;
    oth      = OwnNone;
    case (owner_i)
      OwnM0: begin
        own_req  = m0_req_i;
        oth_req  = m1_req_i;
        own_lock = m0_lock_i;
        oth      = OwnM1;
      end
      OwnM1: begin
        own_req  = m1_req_i;
        oth_req  = m0_req_i;
        own_lock = m1_lock_i;
        oth      = OwnM0;
      end
      default: ;
    endcase
  end

  always_comb begin
    owner_o = OwnNone;
    if (owner_i == OwnM0 || owner_i == OwnM1) begin
      if (xfer_i) begin
        if ((own_lock || !oth_req) && !(oth_req && hold_max_i)) begin
          owner_o = owner_i;
        end else if (oth_req) begin
          owner_o = oth;
        end
      end else if (own_req && !(oth_req && hold_max_i)) begin
        owner_o = owner_i;
      end else if (oth_req) begin
        owner_o = oth;
      end
    end else if (m0_req_i && m1_req_i) begin
      // Tie from idle goes to whoever did not have the bus last.
      owner_o = (last_i == OwnM0) ? OwnM1 : OwnM0;
    end else if (m0_req_i) begin
      owner_o = OwnM0;
    end else if (m1_req_i) begin
      owner_o = OwnM1;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing the SRP16 memory port between the CPU (M0) and a second bus master (M1).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

  owner_e           owner_q, owner_d;
  owner_e           last_q, last_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [1:0]       rd_pend_q, rd_pend_d;
  logic [1:0]       owner_next;
  logic             xfer0, xfer1, xfer, hold_max;

  // Outputs are forced quiet while reset is held so nothing leaks from stale state.
  assign m0_gnt    = (owner_q == OwnM0) & ~reset;
  assign m1_gnt    = (owner_q == OwnM1) & ~reset;
  assign xfer0     = m0_gnt & m0_req;
  assign xfer1     = m1_gnt & m1_req;
  assign xfer      = xfer0 | xfer1;
  assign hold_max  = (hold_q >= HoldW'(MAX_HOLD - 1));
  assign cpu_stall = m0_req & ~m0_gnt;

  bus_arb_pick u_pick (
    .m0_req_i  (m0_req),
    .m1_req_i  (m1_req),
    .m0_lock_i (m0_lock),
    .m1_lock_i (m1_lock),
    .owner_i   (owner_q),
    .last_i    (last_q),
    .xfer_i    (xfer),
    .hold_max_i(hold_max),
    .owner_o   (owner_next)
  );

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (xfer0) begin
      mem_read  = ~m0_we;
      mem_write = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (xfer1) begin
      mem_read  = ~m1_we;
      mem_write = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end
  end

  always_comb begin
    owner_d = owner_e'(owner_next);
    last_d  = last_q;
    if (owner_d != owner_q && owner_d != OwnNone) begin
      last_d = owner_d;
    end
    // Saturate so a long solo run cannot wrap past the hold limit.
    if (owner_d != owner_q) begin
      hold_d = '0;
    end else if (xfer && hold_q < HoldW'(MAX_HOLD)) begin
      hold_d = hold_q + 1'b1;
    end else begin
      hold_d = hold_q;
    end
    rd_pend_d = {xfer1 & ~m1_we, xfer0 & ~m0_we};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q   <= OwnNone;
      last_q    <= OwnM1;
      hold_q    <= '0;
      rd_pend_q <= '0;
    end else begin
      owner_q   <= owner_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign m0_rvalid = rd_pend_q[0] & ~reset;
  assign m1_rvalid = rd_pend_q[1] & ~reset;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single read, alternation, locked burst, write, reset abort.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W  (16),
    .DATA_W  (16),
    .MAX_HOLD(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_we    (m0_we),
    .m0_lock  (m0_lock),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_lock  (m1_lock),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .cpu_stall(cpu_stall)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    {m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock} = '0;
    {m0_addr, m0_wdata, m1_addr, m1_wdata, mem_rdata} = '0;
    cyc();
    cyc();
    #1;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_stall_lo", cpu_stall, 0);
    m0_req = 1'b1;
    #1;
    chk("rst_stall_follows", cpu_stall, 1);

    // Cycle 0: first request after reset
    cyc();
    reset   = 1'b0;
    m0_addr = 16'h0010;
    #1;
    chk("c0_m0_gnt", m0_gnt, 0);
    chk("c0_stall", cpu_stall, 1);
    chk("c0_mem_read", mem_read, 0);
    // Cycle 1: grant and read transfer
    cyc();
    #1;
    chk("c1_m0_gnt", m0_gnt, 1);
    chk("c1_mem_read", mem_read, 1);
    chk("c1_mem_addr", mem_addr, 16'h0010);
    chk("c1_stall", cpu_stall, 0);
    chk("c1_m0_rvalid", m0_rvalid, 0);
    // Cycle 2: read data returns
    cyc();
    m0_req    = 1'b0;
    mem_rdata = 16'hBEEF;
    #1;
    chk("c2_m0_rvalid", m0_rvalid, 1);
    chk("c2_m0_rdata", m0_rdata, 16'hBEEF);
    chk("c2_mem_read", mem_read, 0);
    chk("c2_m1_rvalid", m1_rvalid, 0);
    // Cycle 3: strobe gone, then reset to restore last=M1
    cyc();
    mem_rdata = 16'h0000;
    reset     = 1'b1;
    #1;
    chk("c3_m0_rvalid", m0_rvalid, 0);
    chk("c3_m0_rdata", m0_rdata, 16'h0000);

    // Both request from idle: M0 first, then strict alternation
    cyc();
    reset   = 1'b0;
    m0_req  = 1'b1;
    m1_req  = 1'b1;
    m0_addr = 16'h0100;
    m1_addr = 16'h0200;
    #1;
    chk("alt_idle_m0", m0_gnt, 0);
    chk("alt_idle_m1", m1_gnt, 0);
    cyc();
    #1;
    chk("alt1_m0_gnt", m0_gnt, 1);
    chk("alt1_m1_gnt", m1_gnt, 0);
    chk("alt1_addr", mem_addr, 16'h0100);
    cyc();
    mem_rdata = 16'h5555;
    #1;
    chk("alt2_m1_gnt", m1_gnt, 1);
    chk("alt2_m0_gnt", m0_gnt, 0);
    chk("alt2_addr", mem_addr, 16'h0200);
    chk("alt2_m0_rvalid", m0_rvalid, 1);
    chk("alt2_m0_rdata", m0_rdata, 16'h5555);
    chk("alt2_stall", cpu_stall, 1);
    cyc();
    mem_rdata = 16'hA5A5;
    #1;
    chk("alt3_m0_gnt", m0_gnt, 1);
    chk("alt3_m1_rvalid", m1_rvalid, 1);
    chk("alt3_m1_rdata", m1_rdata, 16'hA5A5);
    chk("alt3_m0_rdata", m0_rdata, 16'h0000);
    cyc();
    m1_lock = 1'b1;
    #1;
    chk("alt4_m1_gnt", m1_gnt, 1);

    // Locked burst: M1 keeps the bus for 8 transfers in total
    for (int i = 0; i < 7; i++) begin
      cyc();
      #1;
      chk("lock_m1_gnt", m1_gnt, 1);
      chk("lock_stall", cpu_stall, 1);
    end
    cyc();
    #1;
    chk("lock_end_m0_gnt", m0_gnt, 1);
    chk("lock_end_m1_gnt", m1_gnt, 0);

    // M1 write while M0 waits
    cyc();
    m1_lock  = 1'b0;
    m1_we    = 1'b1;
    m1_wdata = 16'h1234;
    #1;
    chk("wr_m1_gnt", m1_gnt, 1);
    chk("wr_mem_write", mem_write, 1);
    chk("wr_mem_read", mem_read, 0);
    chk("wr_mem_wdata", mem_wdata, 16'h1234);
    chk("wr_mem_addr", mem_addr, 16'h0200);
    chk("wr_stall", cpu_stall, 1);
    cyc();
    m1_req  = 1'b0;
    m1_we   = 1'b0;
    m0_addr = 16'h0030;
    #1;
    chk("wr_next_m0_gnt", m0_gnt, 1);
    chk("wr_no_rvalid", m1_rvalid, 0);
    chk("rr_mem_read", mem_read, 1);
    chk("rr_mem_addr", mem_addr, 16'h0030);

    // Reset right after an M0 read transfer
    cyc();
    reset  = 1'b1;
    m0_req = 1'b0;
    #1;
    chk("rr_rst_rvalid", m0_rvalid, 0);
    chk("rr_rst_m0_gnt", m0_gnt, 0);
    chk("rr_rst_m1_gnt", m1_gnt, 0);
    chk("rr_rst_mem_read", mem_read, 0);
    cyc();
    reset  = 1'b0;
    m0_req = 1'b1;
    #1;
    chk("rr_post_rvalid", m0_rvalid, 0);
    chk("rr_post_m0_gnt", m0_gnt, 0);
    chk("rr_post_stall", cpu_stall, 1);
    cyc();
    #1;
    chk("rr_regrant", m0_gnt, 1);
    chk("rr_regrant_rvalid", m0_rvalid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
